channel_arbiter: RTL and testbench

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

---
 rtl/channel_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_channel_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/channel_arbiter.sv
// channel_arbiter
//   Round-robin arbiter in front of CH_NUM packet buffers. A channel that
//   reports a complete packet (ch_ready) is granted through a one-hot ch_sel.
//   Its beats are forwarded to a single registered output stream. The grant
//   ends on that buffer's ctrl_eop pulse, or when the idle watchdog expires.
//   Every grant is followed by a one-cycle GAP.
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   ch_ready[CH_NUM]      : per-channel "complete packet stored"
//   ch_ctrl_eop[CH_NUM]   : per-channel "last beat read out" pulse
//   ch_sel[CH_NUM]        : one-hot grant, registered
//   ch_sop/eop/valid/error, ch_data, ch_bytes : per-channel beat inputs
//   o_sop/eop/valid/error, o_data, o_bytes    : merged beat outputs (latency 1)
//   o_grant_id            : index of the current or most recent grant
//   o_busy                : FSM not in IDLE
//   o_timeout             : one-cycle pulse when the watchdog revokes a grant
module channel_arbiter #(
  parameter int  CH_NUM     = 4,
  parameter int  DATA_WIDTH = 128,
  parameter int  TIMEOUT    = 1024,
  localparam int GIDW       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CH_NUM-1:0]            ch_ready,
  input  logic [CH_NUM-1:0]            ch_ctrl_eop,
  output logic [CH_NUM-1:0]            ch_sel,
  input  logic [CH_NUM-1:0]            ch_sop,
  input  logic [CH_NUM-1:0]            ch_eop,
  input  logic [CH_NUM-1:0]            ch_valid,
  input  logic [CH_NUM-1:0]            ch_error,
  input  logic [CH_NUM*DATA_WIDTH-1:0] ch_data,
  input  logic [CH_NUM*4-1:0]          ch_bytes,
  output logic                         o_sop,
  output logic                         o_eop,
  output logic                         o_valid,
  output logic                         o_error,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [3:0]                   o_bytes,
  output logic [GIDW-1:0]              o_grant_id,
  output logic                         o_busy,
  output logic                         o_timeout
);

  // Counter wide enough to hold TIMEOUT itself.
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CH_NUM-1:0] sel_r, sel_s;
  logic [GIDW-1:0]   grant_id_r, grant_id_s;
  logic [GIDW-1:0]   last_id_r, last_id_s;
  logic [WDW-1:0]    wdog_r, wdog_s;
  logic [WDW-1:0]    wdog_inc_s;
  logic              wdog_hit_s;
  logic              timeout_r, timeout_s;
  logic              busy_r;
  logic              found_s;
  logic [GIDW-1:0]   winner_s;
  logic [CH_NUM-1:0] onehot_s;
  logic              sel_valid_s;

  logic              sop_r, eop_r, valid_r, error_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [3:0]        bytes_r;

  assign sel_valid_s = ch_valid[grant_id_r];
  assign wdog_inc_s  = wdog_r + {{(WDW-1){1'b0}}, 1'b1};
  // A TIMEOUT of zero never fires.
  assign wdog_hit_s  = (TIMEOUT != 0) && (wdog_inc_s == WDW'(TIMEOUT));

  // Round-robin search starting just after the previous winner, with wrap.
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    onehot_s = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      int idx;
      idx = (int'(last_id_r) + 1 + i) % CH_NUM;
      if (!found_s && ch_ready[idx]) begin
        found_s  = 1'b1;
        winner_s = GIDW'(idx);
      end else begin
        found_s  = found_s;
      end
    end
    for (int k = 0; k < CH_NUM; k++) begin
      onehot_s[k] = (GIDW'(k) == winner_s);
    end
  end

  // Next-state, grant and watchdog logic.
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    grant_id_s = grant_id_r;
    last_id_s  = last_id_r;
    wdog_s     = wdog_r;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s    = GRANT;
          sel_s      = onehot_s;
          grant_id_s = winner_s;
          last_id_s  = winner_s;
          wdog_s     = '0;
        end else begin
          state_s    = IDLE;
        end
      end
      GRANT: begin
        // ctrl_eop wins over a watchdog expiry in the same cycle.
        if (ch_ctrl_eop[grant_id_r]) begin
          state_s = GAP;
          sel_s   = '0;
          wdog_s  = '0;
        end else if (sel_valid_s) begin
          wdog_s  = '0;
        end else if (wdog_hit_s) begin
          state_s   = GAP;
          sel_s     = '0;
          wdog_s    = wdog_inc_s;
          timeout_s = 1'b1;
        end else if (TIMEOUT != 0) begin
          wdog_s  = wdog_inc_s;
        end else begin
          wdog_s  = wdog_r;
        end
      end
      GAP: begin
        state_s = IDLE;
        sel_s   = '0;
      end
      default: begin
        state_s = IDLE;
        sel_s   = '0;
      end
    endcase
  end

  // FSM, grant and watchdog registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      sel_r      <= '0;
      grant_id_r <= '0;
      last_id_r  <= GIDW'(CH_NUM - 1);
      wdog_r     <= '0;
      timeout_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      grant_id_r <= grant_id_s;
      last_id_r  <= last_id_s;
      wdog_r     <= wdog_s;
      timeout_r  <= timeout_s;
      busy_r     <= (state_s != IDLE);
    end
  end

  // Output beat register; the mux follows grant_id_r, which persists past the
  // grant so beats lagging ch_sel are still forwarded. Payload holds when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      valid_r <= 1'b0;
      error_r <= 1'b0;
      data_r  <= '0;
      bytes_r <= 4'd0;
    end else begin
      valid_r <= sel_valid_s;
      sop_r   <= ch_sop[grant_id_r]   & sel_valid_s;
      eop_r   <= ch_eop[grant_id_r]   & sel_valid_s;
      error_r <= ch_error[grant_id_r] & sel_valid_s;
      if (sel_valid_s) begin
        data_r  <= ch_data[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
        bytes_r <= ch_bytes[int'(grant_id_r)*4 +: 4];
      end
    end
  end

  assign ch_sel     = sel_r;
  assign o_grant_id = grant_id_r;
  assign o_busy     = busy_r;
  assign o_timeout  = timeout_r;
  assign o_sop      = sop_r;
  assign o_eop      = eop_r;
  assign o_valid    = valid_r;
  assign o_error    = error_r;
  assign o_data     = data_r;
  assign o_bytes    = bytes_r;

endmodule

// File: tb/tb_channel_arbiter.sv
// Directed testbench for channel_arbiter (CH_NUM=4, DATA_WIDTH=32, TIMEOUT=8).
module tb_channel_arbiter;

  localparam int CH = 4;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic [CH-1:0]   ch_ready, ch_ctrl_eop, ch_sel;
  logic [CH-1:0]   ch_sop, ch_eop, ch_valid, ch_error;
  logic [CH*DW-1:0] ch_data;
  logic [CH*4-1:0] ch_bytes;
  logic            o_sop, o_eop, o_valid, o_error;
  logic [DW-1:0]   o_data;
  logic [3:0]      o_bytes;
  logic [1:0]      o_grant_id;
  logic            o_busy, o_timeout;

  int n_checks = 0;
  int n_errors = 0;

  channel_arbiter #(.CH_NUM(CH), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .ch_ready(ch_ready), .ch_ctrl_eop(ch_ctrl_eop), .ch_sel(ch_sel),
    .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_valid(ch_valid), .ch_error(ch_error),
    .ch_data(ch_data), .ch_bytes(ch_bytes),
    .o_sop(o_sop), .o_eop(o_eop), .o_valid(o_valid), .o_error(o_error),
    .o_data(o_data), .o_bytes(o_bytes), .o_grant_id(o_grant_id),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_word(input int ch, input int b);
    return 32'hA5000000 | (ch << 16) | b;
  endfunction

  task automatic clear_beats();
    ch_sop = '0; ch_eop = '0; ch_valid = '0; ch_error = '0; ch_ctrl_eop = '0;
  endtask

  // Tick until a grant appears, bounded.
  task automatic wait_grant();
    int cnt;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ch_sel == 4'd0 && cnt < 10);
    check_eq("grant_wait", {63'd0, (ch_sel != 4'd0)}, 64'd1);
  endtask

  // Send n beats on channel ch, check each with latency 1, then release.
  task automatic send_pkt(input int ch, input int n, input bit err);
    logic [3:0] exp_sel;
    exp_sel = 4'd1 << ch;
    for (int b = 0; b < n; b++) begin
      ch_valid[ch] = 1'b1;
      ch_sop[ch]   = (b == 0);
      ch_eop[ch]   = (b == n - 1);
      ch_error[ch] = err && (b == n - 1);
      ch_data[ch*DW +: DW] = beat_word(ch, b);
      ch_bytes[ch*4 +: 4]  = 4'(b + 1);
      tick();
      check_eq("beat_valid", {63'd0, o_valid}, 64'd1);
      check_eq("beat_data",  {32'd0, o_data}, {32'd0, beat_word(ch, b)});
      check_eq("beat_bytes", {60'd0, o_bytes}, 64'(b + 1));
      check_eq("beat_sop",   {63'd0, o_sop}, 64'(b == 0));
      check_eq("beat_eop",   {63'd0, o_eop}, 64'(b == n - 1));
      check_eq("beat_error", {63'd0, o_error}, 64'(err && (b == n - 1)));
      check_eq("beat_sel",   {60'd0, ch_sel}, {60'd0, exp_sel});
    end
    clear_beats();
    ch_ctrl_eop[ch] = 1'b1;
    tick();
    check_eq("rel_sel",   {60'd0, ch_sel}, 64'd0);
    check_eq("rel_valid", {63'd0, o_valid}, 64'd0);
    check_eq("rel_hold",  {32'd0, o_data}, {32'd0, beat_word(ch, n - 1)});
    check_eq("rel_busy",  {63'd0, o_busy}, 64'd1);
    ch_ctrl_eop = '0;
  endtask

  initial begin
    int prev;
    reset = 1'b1; ch_ready = '0; ch_data = '0; ch_bytes = '0;
    clear_beats();
    tick(); tick();
    check_eq("rst_sel",     {60'd0, ch_sel}, 64'd0);
    check_eq("rst_busy",    {63'd0, o_busy}, 64'd0);
    check_eq("rst_gid",     {62'd0, o_grant_id}, 64'd0);
    check_eq("rst_valid",   {63'd0, o_valid}, 64'd0);
    check_eq("rst_data",    {32'd0, o_data}, 64'd0);
    check_eq("rst_timeout", {63'd0, o_timeout}, 64'd0);
    reset = 1'b0;

    // Single request on ch2.
    ch_ready = 4'b0100;
    tick();
    check_eq("single_sel",  {60'd0, ch_sel}, 64'h4);
    check_eq("single_gid",  {62'd0, o_grant_id}, 64'd2);
    check_eq("single_busy", {63'd0, o_busy}, 64'd1);
    ch_ready = '0;
    send_pkt(2, 2, 1'b1);
    tick();
    check_eq("single_idle", {63'd0, o_busy}, 64'd0);
    check_eq("single_gid_hold", {62'd0, o_grant_id}, 64'd2);

    // Round robin from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ch_ready = 4'b1111;
    prev = -1;
    for (int p = 0; p < 5; p++) begin
      wait_grant();
      check_eq("rr_gid",  {62'd0, o_grant_id}, 64'(p % 4));
      check_eq("rr_sel",  {60'd0, ch_sel}, 64'(1 << (p % 4)));
      check_eq("rr_nodup", {63'd0, (int'(o_grant_id) != prev)}, 64'd1);
      prev = int'(o_grant_id);
      send_pkt(p % 4, 3, 1'b0);
    end

    // Noise on ch3 while ch1 is granted.
    ch_ready = 4'b0010;
    wait_grant();
    check_eq("noise_gid", {62'd0, o_grant_id}, 64'd1);
    ch_ready = 4'b1000;
    ch_valid[3] = 1'b1; ch_ctrl_eop[3] = 1'b1; ch_sop[3] = 1'b1;
    ch_data[3*DW +: DW] = 32'hBAD0BAD0;
    tick();
    clear_beats();
    check_eq("noise_valid", {63'd0, o_valid}, 64'd0);
    check_eq("noise_sel",   {60'd0, ch_sel}, 64'h2);
    check_eq("noise_busy",  {63'd0, o_busy}, 64'd1);
    send_pkt(1, 2, 1'b0);

    // Watchdog: ch0 granted, no beats.
    ch_ready = 4'b0011;
    wait_grant();
    check_eq("to_gid", {62'd0, o_grant_id}, 64'd0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check_eq("to_quiet", {59'd0, o_timeout, ch_sel}, 64'h1);
    end
    tick();
    check_eq("to_pulse", {63'd0, o_timeout}, 64'd1);
    check_eq("to_sel",   {60'd0, ch_sel}, 64'd0);
    tick();
    check_eq("to_pulse_end", {63'd0, o_timeout}, 64'd0);
    tick();
    check_eq("to_next_gid", {62'd0, o_grant_id}, 64'd1);
    check_eq("to_next_sel", {60'd0, ch_sel}, 64'h2);
    ch_ready = '0;

    // ctrl_eop in the cycle the watchdog would expire.
    for (int k = 1; k < 8; k++) begin
      tick();
      check_eq("sim_quiet", {59'd0, o_timeout, ch_sel}, 64'h2);
    end
    ch_ctrl_eop[1] = 1'b1;
    tick();
    ch_ctrl_eop = '0;
    check_eq("sim_timeout", {63'd0, o_timeout}, 64'd0);
    check_eq("sim_sel",     {60'd0, ch_sel}, 64'd0);
    tick();
    check_eq("sim_timeout2", {63'd0, o_timeout}, 64'd0);
    check_eq("sim_idle",     {63'd0, o_busy}, 64'd0);

    // Reset during beat 2 of 5.
    ch_ready = 4'b0110;
    wait_grant();
    check_eq("mid_gid", {62'd0, o_grant_id}, 64'd2);
    ch_valid[2] = 1'b1; ch_sop[2] = 1'b1;
    ch_data[2*DW +: DW] = beat_word(2, 0); ch_bytes[2*4 +: 4] = 4'd9;
    tick();
    check_eq("mid_beat1", {63'd0, o_valid}, 64'd1);
    ch_sop[2] = 1'b0;
    ch_data[2*DW +: DW] = beat_word(2, 1);
    reset = 1'b1;
    tick();
    check_eq("mid_sel",   {60'd0, ch_sel}, 64'd0);
    check_eq("mid_valid", {63'd0, o_valid}, 64'd0);
    check_eq("mid_data",  {32'd0, o_data}, 64'd0);
    check_eq("mid_bytes", {60'd0, o_bytes}, 64'd0);
    check_eq("mid_gid0",  {62'd0, o_grant_id}, 64'd0);
    check_eq("mid_busy",  {63'd0, o_busy}, 64'd0);
    reset = 1'b0;
    clear_beats();
    tick();
    check_eq("post_rst_gid", {62'd0, o_grant_id}, 64'd1);
    check_eq("post_rst_sel", {60'd0, ch_sel}, 64'h2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
